// File: rtl/mem_wb_pkg.sv
// Shared constants and types for the memory/write-back stage of the 16-bit pipeline.
package mem_wb_pkg;

  localparam int MEM_WB_DSIZE = 16;
  localparam int RF_AW        = 3;
  localparam int ST_W         = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_pr.sv
// Mem:WB pipeline register; a bubble clears the write enable and holds the other fields.
module mem_wb_pr
  import mem_wb_pkg::*;
#(
  parameter int DSIZE = MEM_WB_DSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble,
  input  logic             we_in,
  input  logic [RF_AW-1:0] addr_in,
  input  logic [DSIZE-1:0] wdata_in,
  input  logic [ST_W-1:0]  status_in,
  output logic             we_o,
  output logic [RF_AW-1:0] addr_o,
  output logic [DSIZE-1:0] wdata_o,
  output logic [ST_W-1:0]  status_o
);

  logic             we_q, we_d;
  logic [RF_AW-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [ST_W-1:0]  status_q, status_d;

  always_comb begin
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    status_d = status_q;
    if (!bubble) begin
      we_d     = we_in;
      addr_d   = addr_in;
      wdata_d  = wdata_in;
      status_d = status_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      status_q <= '0;
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      status_q <= status_d;
    end
  end

  assign we_o     = we_q;
  assign addr_o   = addr_q;
  assign wdata_o  = wdata_q;
  assign status_o = status_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: req/ack data-memory access with upstream stall,
// wait-cycle timeout and the Mem:WB register feeding the register-file write port.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DSIZE   = MEM_WB_DSIZE,
  parameter int TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             sel_mem2Reg,
  input  logic             RFwriteEnab,
  input  logic [DSIZE-1:0] ALUresult,
  input  logic [RF_AW-1:0] RFdest_rd,
  input  logic [ST_W-1:0]  ALUstatus,
  input  logic             memEnab,
  input  logic             memWriteEnab,
  input  logic [DSIZE-1:0] memWdata,
  output logic             stall_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic [DSIZE-1:0] dmem_addr_o,
  output logic [DSIZE-1:0] dmem_wdata_o,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             RFwe_o,
  output logic [RF_AW-1:0] RFaddr_o,
  output logic [DSIZE-1:0] RFwdata_o,
  output logic [ST_W-1:0]  status_o,
  output logic             err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             we_q, we_d;
  logic [DSIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             in_wait, start, timeout, bubble;
  logic [DSIZE-1:0] wb_data;

  assign in_wait = (state_q == WAIT);
  assign start   = !in_wait && memEnab;
  // The last unacknowledged wait cycle aborts; an ack in that same cycle still completes.
  assign timeout = in_wait && !dmem_ack && (cnt_q == CNT_LAST);
  assign bubble  = start || (in_wait && !dmem_ack);
  assign wb_data = (in_wait && sel_mem2Reg) ? dmem_rdata : ALUresult;
  assign err_d   = err_q | timeout;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memEnab) state_d = WAIT;
      WAIT:    if (dmem_ack || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    dmem_req_o = in_wait;
    dmem_we_o  = in_wait && we_q;
    stall_o    = 1'b0;
    if (Rst_n) begin
      case (state_q)
        IDLE:    stall_o = memEnab;
        WAIT:    stall_o = !dmem_ack && !timeout;
        default: stall_o = 1'b0;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      cnt_d   = '0;
      we_d    = memWriteEnab;
      addr_d  = ALUresult;
      wdata_d = memWdata;
    end else if (in_wait && !dmem_ack && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign err_o        = err_q;

  mem_wb_pr #(.DSIZE(DSIZE)) u_mem_wb_pr (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .bubble   (bubble),
    .we_in    (RFwriteEnab),
    .addr_in  (RFdest_rd),
    .wdata_in (wb_data),
    .status_in(ALUstatus),
    .we_o     (RFwe_o),
    .addr_o   (RFaddr_o),
    .wdata_o  (RFwdata_o),
    .status_o (status_o)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a transaction-level model of the access outcome.
module tb_mem_wb_stage;

  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        sel_mem2Reg = 1'b0;
  logic        RFwriteEnab = 1'b0;
  logic [15:0] ALUresult = '0;
  logic [2:0]  RFdest_rd = '0;
  logic [3:0]  ALUstatus = '0;
  logic        memEnab = 1'b0;
  logic        memWriteEnab = 1'b0;
  logic [15:0] memWdata = '0;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [15:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        RFwe_o;
  logic [2:0]  RFaddr_o;
  logic [15:0] RFwdata_o;
  logic [3:0]  status_o;
  logic        err_o;

  mem_wb_stage #(.DSIZE(16), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .sel_mem2Reg(sel_mem2Reg), .RFwriteEnab(RFwriteEnab),
    .ALUresult(ALUresult), .RFdest_rd(RFdest_rd), .ALUstatus(ALUstatus),
    .memEnab(memEnab), .memWriteEnab(memWriteEnab), .memWdata(memWdata),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .RFwe_o(RFwe_o), .RFaddr_o(RFaddr_o),
    .RFwdata_o(RFwdata_o), .status_o(status_o), .err_o(err_o)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected values of the registered write-back outputs currently visible.
  logic        m_we = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [15:0] m_wd = '0;
  logic [3:0]  m_st = '0;
  logic        m_err = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_wb();
    check_val("RFwe", 32'(RFwe_o), 32'(m_we));
    check_val("RFaddr", 32'(RFaddr_o), 32'(m_addr));
    check_val("RFwdata", 32'(RFwdata_o), 32'(m_wd));
    check_val("status", 32'(status_o), 32'(m_st));
    check_val("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_addr = '0; m_wd = '0; m_st = '0; m_err = 1'b0;
  endtask

  // Non-memory instruction; a stray ack (with sel_mem2Reg set) must not change the result.
  task automatic do_alu(input logic we, input logic [15:0] res, input logic [2:0] rd,
                        input logic [3:0] st, input logic sel, input logic stray_ack);
    memEnab = 1'b0; memWriteEnab = 1'($urandom); memWdata = 16'($urandom);
    RFwriteEnab = we; ALUresult = res; RFdest_rd = rd; ALUstatus = st; sel_mem2Reg = sel;
    dmem_ack = stray_ack; dmem_rdata = ~res;
    @(negedge Clk);
    check_wb();
    check_val("alu_stall", 32'(stall_o), 32'd0);
    check_val("alu_req", 32'(dmem_req_o), 32'd0);
    check_val("alu_dwe", 32'(dmem_we_o), 32'd0);
    @(posedge Clk); #1;
    dmem_ack = 1'b0;
    m_we = we; m_addr = rd; m_wd = res; m_st = st;
  endtask

  // Memory access acknowledged in wait cycle n (1..); n == 0 or n > TO means never acked.
  task automatic do_mem(input logic store, input logic sel, input logic we,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [2:0] rd, input logic [3:0] st, input int n);
    int stalls;
    logic [15:0] rd_data;
    stalls = 0;
    memEnab = 1'b1; memWriteEnab = store; memWdata = wdata; ALUresult = addr;
    RFwriteEnab = we; RFdest_rd = rd; ALUstatus = st; sel_mem2Reg = sel;
    @(negedge Clk);
    check_wb();
    check_val("mem_stall0", 32'(stall_o), 32'd1);
    check_val("mem_req0", 32'(dmem_req_o), 32'd0);
    if (stall_o) stalls++;
    @(posedge Clk); #1;
    m_we = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      rd_data = 16'($urandom);
      dmem_rdata = rd_data;
      dmem_ack = (k == n);
      @(negedge Clk);
      check_wb();
      check_val("req", 32'(dmem_req_o), 32'd1);
      check_val("dmem_we", 32'(dmem_we_o), 32'(store));
      check_val("dmem_addr", 32'(dmem_addr_o), 32'(addr));
      check_val("dmem_wdata", 32'(dmem_wdata_o), 32'(wdata));
      check_val("stall", 32'(stall_o), 32'((k != n) && (k != TO)));
      if (stall_o) stalls++;
      @(posedge Clk); #1;
      dmem_ack = 1'b0;
      if (k == n) begin
        m_we = we; m_addr = rd; m_wd = sel ? rd_data : addr; m_st = st;
        break;
      end
      if (k == TO) begin
        m_we = 1'b0;
        m_err = 1'b1;
      end
    end
    check_val("stall_cycles", 32'(stalls), (n >= 1 && n <= TO) ? 32'(n) : 32'(TO));
  endtask

  // Reset asserted a few cycles into a wait; request must drop at once.
  task automatic do_reset_mid_wait();
    memEnab = 1'b1; memWriteEnab = 1'b1; ALUresult = 16'h0abc; memWdata = 16'h5a5a;
    RFwriteEnab = 1'b1; RFdest_rd = 3'd6; ALUstatus = 4'h9; sel_mem2Reg = 1'b1;
    repeat (3) begin @(posedge Clk); end
    #1;
    check_val("rst_pre_req", 32'(dmem_req_o), 32'd1);
    Rst_n = 1'b0;
    #1;
    model_reset();
    check_wb();
    check_val("rst_req", 32'(dmem_req_o), 32'd0);
    check_val("rst_dwe", 32'(dmem_we_o), 32'd0);
    check_val("rst_stall", 32'(stall_o), 32'd0);
    check_val("rst_daddr", 32'(dmem_addr_o), 32'd0);
    check_val("rst_dwdata", 32'(dmem_wdata_o), 32'd0);
    @(negedge Clk);
    memEnab = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    do_alu(1'b0, 16'h0777, 3'd1, 4'h2, 1'b1, 1'b1);
    check_val("late_ack_req", 32'(dmem_req_o), 32'd0);
  endtask

  initial begin
    int n;
    @(negedge Clk);
    check_wb();
    check_val("init_stall", 32'(stall_o), 32'd0);
    check_val("init_req", 32'(dmem_req_o), 32'd0);
    check_val("init_dwe", 32'(dmem_we_o), 32'd0);
    check_val("init_daddr", 32'(dmem_addr_o), 32'd0);
    check_val("init_dwdata", 32'(dmem_wdata_o), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    do_alu(1'b1, 16'h1234, 3'd5, 4'h3, 1'b0, 1'b0);
    do_mem(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000, 3'd2, 4'h1, 3);
    do_mem(1'b1, 1'b0, 1'b0, 16'h0010, 16'h00aa, 3'd0, 4'h0, 1);
    do_alu(1'b1, 16'h4321, 3'd7, 4'hc, 1'b0, 1'b1);
    do_mem(1'b0, 1'b1, 1'b1, 16'h0044, 16'h0000, 3'd3, 4'h4, TO);
    do_mem(1'b0, 1'b1, 1'b1, 16'h0048, 16'h0000, 3'd4, 4'h5, 0);
    do_alu(1'b1, 16'h5555, 3'd6, 4'h7, 1'b0, 1'b0);
    do_alu(1'b0, 16'h0001, 3'd2, 4'h8, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_alu(1'($urandom), 16'($urandom), 3'($urandom), 4'($urandom),
               1'($urandom), 1'($urandom));
      end else begin
        n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
        do_mem(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
               3'($urandom), 4'($urandom), n);
      end
    end

    do_reset_mid_wait();
    do_mem(1'b0, 1'b1, 1'b1, 16'h0100, 16'h0000, 3'd5, 4'h6, 2);
    do_alu(1'b0, 16'h0000, 3'd0, 4'h0, 1'b0, 1'b0);
    @(negedge Clk);
    check_wb();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/write-back stage of the 16-bit 5-stage pipeline. Consumes the EX:Mem pipeline register outputs and drives a variable-latency data memory over a req/ack handshake. Holds the Mem:WB pipeline register and drives the register-file write port. Stalls upstream stages while a memory access is outstanding and flags accesses that never complete.

## Interface
- DSIZE, 16, data/ALU width
- TIMEOUT, 15, max WAIT cycles before abort (1..255)
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- sel_mem2Reg  in  1  from EX:Mem; 1 = write-back data comes from memory
- RFwriteEnab  in  1  from EX:Mem; instruction writes RF
- ALUresult  in  DSIZE  from EX:Mem; result, or memory address for memory ops
- RFdest_rd  in  3  from EX:Mem; RF destination
- ALUstatus  in  4  from EX:Mem; ALU flags
- memEnab  in  1  memory access this instruction
- memWriteEnab  in  1  access is a store (valid with memEnab)
- memWdata  in  DSIZE  store data
- stall_o  out  1  freeze PC, IF:ID, ID:EX, EX:Mem
- dmem_req_o, dmem_we_o  out  1 each  memory request / write strobe
- dmem_addr_o, dmem_wdata_o  out  DSIZE each  registered address / store data
- dmem_ack  in  1  memory completion, one-cycle pulse
- dmem_rdata  in  DSIZE  load data, valid with dmem_ack
- RFwe_o  out  1  RF write enable
- RFaddr_o  out  3  RF write address
- RFwdata_o  out  DSIZE  RF write data
- status_o  out  4  registered ALU flags
- err_o  out  1  sticky timeout flag

## Operation
- FSM states IDLE, WAIT.
- IDLE, memEnab=0: stall_o=0; Mem:WB register loads RFwe_o<=RFwriteEnab, RFaddr_o<=RFdest_rd, RFwdata_o<=ALUresult, status_o<=ALUstatus.
- IDLE, memEnab=1: stall_o=1; capture dmem_addr_o<=ALUresult, dmem_wdata_o<=memWdata, dmem_we_o<=memWriteEnab; clear wait counter; go WAIT; Mem:WB loads bubble (RFwe_o<=0, other fields hold).
- WAIT: dmem_req_o=1 (Moore). stall_o = !dmem_ack (combinational).
  - ack=1: go IDLE. Mem:WB loads RFwe_o<=RFwriteEnab, RFaddr_o<=RFdest_rd, RFwdata_o<=(sel_mem2Reg ? dmem_rdata : ALUresult), status_o<=ALUstatus.
  - ack=0: counter++, bubble into Mem:WB. At counter==TIMEOUT, set err_o, go IDLE with stall_o=0, and load Mem:WB with RFwe_o=0 (instruction retires without write).
- err_o is sticky; cleared only by reset.
- dmem_req_o/dmem_we_o are 0 in IDLE. dmem_we_o is meaningful only with req.
- Ack arriving while IDLE is ignored.
- Counter width is ceil(log2(TIMEOUT+1)). Saturates; never wraps.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, every output 0 (stall_o=0, dmem_* =0, RFwe_o=0, RFaddr_o=0, RFwdata_o=0, status_o=0, err_o=0), counter 0.
- Non-memory instruction: RF write visible 1 cycle after EX:Mem presents it.
- Memory op presented at cycle t: req high from t+1. Ack at cycle t+n (n≥1): RF write visible at t+n+1. Stall high for cycles t..t+n-1 (n cycles).
- Ack in the same cycle that the counter reaches TIMEOUT: ack wins, normal completion, err_o unchanged.
- Reset mid-WAIT: request dropped immediately. A late ack after reset is ignored.

## Structure
- Shared package/constants: FSM state encoding (IDLE=1'b0, WAIT=1'b1), DSIZE, RF address width 3, status width 4.
- Single sub-module natural: mem_wb_pr (Mem:WB register with bubble insert, async active-low reset). Rest (FSM, timeout counter, request regs) lives in mem_wb_stage.

## Test plan
- ALU op: RFwriteEnab=1, ALUresult=0x1234, rd=5, ALUstatus=0x3, memEnab=0 -> next cycle RFwe_o=1, RFaddr_o=5, RFwdata_o=0x1234, status_o=0x3, stall_o=0 throughout.
- Load, ack after 3 WAIT cycles: addr 0x0040, rdata 0xBEEF, sel_mem2Reg=1, rd=2 -> req high 3 cycles, stall_o high 3 cycles, then RFwe_o=1, RFaddr_o=2, RFwdata_o=0xBEEF; RFwe_o=0 during bubbles.
- Store: memWriteEnab=1, addr 0x0010, wdata 0x00AA, ack after 1 cycle -> dmem_we_o=1, dmem_addr_o=0x0010, dmem_wdata_o=0x00AA with req; RFwe_o=0 after completion (RFwriteEnab=0).
- Timeout: TIMEOUT=15, never ack -> after 15 WAIT cycles err_o=1 (stays 1), stall_o drops, RFwe_o=0, next ALU op writes normally.
- Ack on the cycle the counter reaches TIMEOUT -> normal load write-back, err_o stays 0.
- Rst_n low mid-WAIT, then ack pulse after release -> all outputs 0 immediately on reset, state IDLE, stray ack causes no RF write.
